// File: rtl/fetch_pkg.sv
// Shared types, constants and the address-legality helper for the fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD    = 32'h0000_0000;
  localparam int          PC_STEP      = 4;
  localparam int          IMEM_BYTE_AW = 8;

  // Legal fetch address: word aligned and inside the 256-byte instruction memory.
  function automatic logic legal_addr(input logic [63:0] addr);
    return (addr[1:0] == 2'b00) && (addr[63:IMEM_BYTE_AW] == '0);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID outputs.
interface fetch_if #(
    parameter int N  = 64,
    parameter int AW = 6
);
  logic          stall;
  logic          br_taken;
  logic [N-1:0]  br_target;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic [31:0]   if_instr;
  logic [N-1:0]  if_pc;
  logic          if_valid;
  logic          halted;
  logic          fault;
  logic [31:0]   instr_count;

  modport master (
    input  stall, br_taken, br_target, imem_q,
    output imem_addr, if_instr, if_pc, if_valid, halted, fault, instr_count
  );

  modport slave (
    output stall, br_taken, br_target, imem_q,
    input  imem_addr, if_instr, if_pc, if_valid, halted, fault, instr_count
  );
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load captures a new instruction, flush drops its valid bit.
module ifid_reg #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         flush,
    input  logic [31:0]  instr_d,
    input  logic [N-1:0] pc_d,
    output logic [31:0]  instr,
    output logic [N-1:0] pc,
    output logic         valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      pc    <= pc_d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch: PC, RUN/HALT/FAULT control, IF/ID register and delivery counter.
module fetch_unit
  import fetch_pkg::*;
#(
    parameter int N          = 64,
    parameter int IMEM_WORDS = 64
) (
    input logic      clk,
    input logic      reset,
    fetch_if.master  bus
);

  localparam int AW = $clog2(IMEM_WORDS);

  fetch_state_t state, state_nx;
  logic [N-1:0] pc, pc_nx, pc_inc;
  logic         end_pending, end_nx;
  logic [31:0]  count;
  logic         load, flush;
  logic         target_ok, inc_ok;
  logic [31:0]  ifid_instr;
  logic [N-1:0] ifid_pc;
  logic         ifid_valid;

  always_comb begin
    pc_inc    = pc + N'(PC_STEP);
    target_ok = legal_addr(64'(bus.br_target));
    inc_ok    = legal_addr(64'(pc_inc));
    state_nx  = state;
    pc_nx     = pc;
    end_nx    = end_pending;
    load      = 1'b0;
    flush     = 1'b0;
    case (state)
      RUN: begin
        if (bus.br_taken) begin
          flush  = 1'b1;
          end_nx = 1'b0;
          if (target_ok) pc_nx = bus.br_target;
          else           state_nx = FAULT;
        end else if (end_pending) begin
          // Last word was already delivered at the top of memory; fault one cycle later.
          flush    = 1'b1;
          state_nx = FAULT;
        end else if (!bus.stall) begin
          if (bus.imem_q == HALT_WORD) begin
            flush    = 1'b1;
            state_nx = HALT;
          end else begin
            load = 1'b1;
            if (inc_ok) pc_nx  = pc_inc;
            else        end_nx = 1'b1;
          end
        end
      end
      HALT: begin
        flush = 1'b1;
        if (bus.br_taken) begin
          if (target_ok) begin
            state_nx = RUN;
            pc_nx    = bus.br_target;
          end else begin
            state_nx = FAULT;
          end
        end
      end
      default: flush = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= '0;
      end_pending <= 1'b0;
      count       <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      end_pending <= end_nx;
      if (load && (count != '1)) count <= count + 32'd1;
    end
  end

  ifid_reg #(.N(N)) u_ifid (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .flush   (flush),
    .instr_d (bus.imem_q),
    .pc_d    (pc),
    .instr   (ifid_instr),
    .pc      (ifid_pc),
    .valid   (ifid_valid)
  );

  assign bus.imem_addr   = pc[AW+1:2];
  assign bus.if_instr    = ifid_instr;
  assign bus.if_pc       = ifid_pc;
  assign bus.if_valid    = ifid_valid;
  assign bus.halted      = (state == HALT);
  assign bus.fault       = (state == FAULT);
  assign bus.instr_count = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a delivery scoreboard.
module tb_fetch_unit;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem [64];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  fetch_if #(.N(64), .AW(6)) bus ();

  fetch_unit #(.N(64), .IMEM_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_q = mem[bus.imem_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc);
    exp_t e;
    logic [5:0] a;
    a = pc[7:2];
    e.pc    = pc;
    e.instr = mem[a];
    sb.push_back(e);
  endtask

  // One clock edge; if deliver, pop the scoreboard and compare IF/ID contents.
  task automatic tick(input bit deliver, input bit exp_valid);
    exp_t e;
    @(posedge clk);
    #1;
    if (deliver) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow observed=empty expected=entry");
      end else begin
        e = sb.pop_front();
        check("if_pc", 64'(bus.if_pc), e.pc);
        check("if_instr", 64'(bus.if_instr), 64'(e.instr));
      end
      check("if_valid", 64'(bus.if_valid), 64'd1);
    end else begin
      check("if_valid", 64'(bus.if_valid), 64'(exp_valid));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_imem_addr"}, 64'(bus.imem_addr), 64'd0);
    check({tag, "_if_instr"}, 64'(bus.if_instr), 64'd0);
    check({tag, "_if_pc"}, bus.if_pc, 64'd0);
    check({tag, "_halted"}, 64'(bus.halted), 64'd0);
    check({tag, "_fault"}, 64'(bus.fault), 64'd0);
    check({tag, "_count"}, 64'(bus.instr_count), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h9100_0000 + 32'(i);
    mem[0] = 32'hf800_0000;
    mem[1] = 32'hf800_8001;
    mem[2] = 32'h0000_0000;
    bus.stall     = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = '0;

    // Reset and short program ending in HALT_WORD
    reset = 1'b1;
    tick(0, 0);
    check_reset_state("rst0");
    reset = 1'b0;
    push(64'h0);
    push(64'h4);
    tick(1, 1);
    tick(1, 1);
    tick(0, 0);
    check("halt_halted", 64'(bus.halted), 64'd1);
    check("halt_count", 64'(bus.instr_count), 64'd2);
    check("halt_addr", 64'(bus.imem_addr), 64'd2);

    // Stall at pc = 0x8
    mem[2] = 32'h9100_0002;
    reset = 1'b1;
    tick(0, 0);
    reset = 1'b0;
    push(64'h0);
    push(64'h4);
    tick(1, 1);
    tick(1, 1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 1);
      check("stall_addr", 64'(bus.imem_addr), 64'd2);
      check("stall_instr", 64'(bus.if_instr), 64'hf800_8001);
      check("stall_count", 64'(bus.instr_count), 64'd2);
    end
    bus.stall = 1'b0;
    push(64'h8);
    tick(1, 1);
    check("unstall_count", 64'(bus.instr_count), 64'd3);
    push(64'hC);
    tick(1, 1);
    check("pre_br_addr", 64'(bus.imem_addr), 64'd4);

    // Branch redirect, then branch with stall in the same cycle
    bus.br_taken  = 1'b1;
    bus.br_target = 64'h40;
    tick(0, 0);
    check("br_addr", 64'(bus.imem_addr), 64'd16);
    bus.br_taken = 1'b0;
    push(64'h40);
    tick(1, 1);
    check("br_count", 64'(bus.instr_count), 64'd5);
    bus.br_taken  = 1'b1;
    bus.stall     = 1'b1;
    bus.br_target = 64'h80;
    tick(0, 0);
    check("brst_addr", 64'(bus.imem_addr), 64'd32);
    bus.br_taken = 1'b0;
    bus.stall    = 1'b0;
    push(64'h80);
    tick(1, 1);

    // Misaligned target faults; fault is sticky under branches and stall
    bus.br_taken  = 1'b1;
    bus.br_target = 64'h42;
    tick(0, 0);
    check("mis_fault", 64'(bus.fault), 64'd1);
    check("mis_addr", 64'(bus.imem_addr), 64'd33);
    bus.br_target = 64'h40;
    bus.stall     = 1'b1;
    tick(0, 0);
    tick(0, 0);
    check("sticky_fault", 64'(bus.fault), 64'd1);
    check("sticky_addr", 64'(bus.imem_addr), 64'd33);
    check("sticky_count", 64'(bus.instr_count), 64'd6);
    reset = 1'b1;
    tick(0, 0);
    check_reset_state("rst_fault");
    reset = 1'b0;
    bus.br_taken = 1'b0;
    bus.stall    = 1'b0;

    // Out-of-range target
    push(64'h0);
    tick(1, 1);
    bus.br_taken  = 1'b1;
    bus.br_target = 64'h100;
    tick(0, 0);
    check("oor_fault", 64'(bus.fault), 64'd1);
    check("oor_addr", 64'(bus.imem_addr), 64'd1);
    bus.br_taken = 1'b0;

    // Straight-line code running off the end of memory
    reset = 1'b1;
    tick(0, 0);
    reset = 1'b0;
    bus.br_taken  = 1'b1;
    bus.br_target = 64'hF0;
    tick(0, 0);
    bus.br_taken = 1'b0;
    push(64'hF0);
    push(64'hF4);
    push(64'hF8);
    push(64'hFC);
    for (int i = 0; i < 4; i++) tick(1, 1);
    check("end_addr", 64'(bus.imem_addr), 64'd63);
    check("end_fault_pre", 64'(bus.fault), 64'd0);
    check("end_count", 64'(bus.instr_count), 64'd4);
    tick(0, 0);
    check("end_fault", 64'(bus.fault), 64'd1);
    check("end_addr_hold", 64'(bus.imem_addr), 64'd63);
    check("end_count_hold", 64'(bus.instr_count), 64'd4);

    // Reset mid-stall
    reset = 1'b1;
    tick(0, 0);
    reset = 1'b0;
    push(64'h0);
    tick(1, 1);
    bus.stall = 1'b1;
    tick(0, 1);
    reset = 1'b1;
    tick(0, 0);
    check_reset_state("rst_stall");
    reset = 1'b0;
    bus.stall = 1'b0;
    push(64'h0);
    tick(1, 1);

    // HALT: stall ignored, branch rescue, then reset in HALT
    mem[2] = 32'h0000_0000;
    push(64'h4);
    tick(1, 1);
    tick(0, 0);
    check("h2_halted", 64'(bus.halted), 64'd1);
    bus.stall = 1'b1;
    tick(0, 0);
    check("h2_halted_stall", 64'(bus.halted), 64'd1);
    bus.stall     = 1'b0;
    bus.br_taken  = 1'b1;
    bus.br_target = 64'h10;
    tick(0, 0);
    check("rescue_halted", 64'(bus.halted), 64'd0);
    check("rescue_addr", 64'(bus.imem_addr), 64'd4);
    bus.br_taken = 1'b0;
    push(64'h10);
    tick(1, 1);
    check("rescue_count", 64'(bus.instr_count), 64'd3);
    push(64'h14);
    tick(1, 1);
    push(64'h18);
    tick(1, 1);
    mem[7] = 32'h0000_0000;
    tick(0, 0);
    check("h3_halted", 64'(bus.halted), 64'd1);
    reset = 1'b1;
    tick(0, 0);
    check_reset_state("rst_halt");
    reset = 1'b0;
    push(64'h0);
    tick(1, 1);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
